// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state encoding, decoder line indices and accumulator source codes for cpu_ctrl_seq
//   S_STEP exists only when CPU_CTRL_SINGLE_STEP_EN is defined.
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM,
    S_IO_IN,
    S_IO_OUT,
    S_HALT,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    S_FAULT,
    S_STEP
`else
    S_FAULT
`endif
  } state_t;
  localparam int D_MOVA = 0;
  localparam int D_MOVB = 1;
  localparam int D_MOVC = 2;
  localparam int D_MOVD = 3;
  localparam int D_ADD  = 4;
  localparam int D_SUB  = 5;
  localparam int D_JMP  = 6;
  localparam int D_JG   = 7;
  localparam int D_IN1  = 8;
  localparam int D_OUT1 = 9;
  localparam int D_MOVI = 10;
  localparam int D_HALT = 11;
  localparam logic [1:0] ACC_ALU = 2'd0;
  localparam logic [1:0] ACC_IN  = 2'd1;
  localparam logic [1:0] ACC_IMM = 2'd2;
  function automatic logic is_onehot(input logic [11:0] v);
    return v != '0 && (v & (v - 12'd1)) == '0;
  endfunction
endpackage

// File: rtl/cpu_wait_timer.sv
// cpu_wait_timer: memory wait-state counter with timeout flag
//   clk, rst_n (async active-low), clr (sync clear), en (count a wait cycle),
//   expired (this wait cycle is the MAX-th one)
module cpu_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expired = en && cnt == 8'(MAX - 1);
endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode CPU
//   in : clk, rst_n (async active-low), start, mem_ack, dec_vec[11:0], gt_flag, in_valid, out_ready
//        step (only with CPU_CTRL_SINGLE_STEP_EN)
//   out: mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, dec_en, reg_we, reg_sel[1:0], acc_ld, alu_sub,
//        acc_src[1:0], in_ready, out_valid, halted, fault, illegal, insn_cnt[CNT_W-1:0]
//   CPU_CTRL_SINGLE_STEP_EN: park in STEP after each retire until step=1.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mem_ack,
  input  logic [11:0]      dec_vec,
  input  logic             gt_flag,
  input  logic             in_valid,
  input  logic             out_ready,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             mem_rd,
  output logic             ir_ld,
  output logic             imm_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             dec_en,
  output logic             reg_we,
  output logic [1:0]       reg_sel,
  output logic             acc_ld,
  output logic             alu_sub,
  output logic [1:0]       acc_src,
  output logic             in_ready,
  output logic             out_valid,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] insn_cnt
);
`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam state_t RET_ST = S_STEP;
`else
  localparam state_t RET_ST = S_FETCH;
`endif
  state_t state, nxt;
  logic [11:0] dec_q, op;
  logic retire, expired, wait_en;
  assign wait_en = (state == S_FETCH || state == S_IMM) && !mem_ack;
  cpu_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (nxt != state),
    .en     (wait_en),
    .expired(expired)
  );
  // zero or multi-hot decode collapses to a NOP with no strobes
  assign op = is_onehot(dec_q) ? dec_q : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_IDLE;
      dec_q    <= '0;
      insn_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) dec_q <= dec_vec;
      if (retire) insn_cnt <= insn_cnt + CNT_W'(1);
    end
  always_comb begin
    nxt       = state;
    retire    = 1'b0;
    mem_rd    = 1'b0;
    ir_ld     = 1'b0;
    imm_ld    = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    dec_en    = 1'b0;
    reg_we    = 1'b0;
    reg_sel   = 2'd0;
    acc_ld    = 1'b0;
    alu_sub   = 1'b0;
    acc_src   = ACC_ALU;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      S_IDLE: nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = mem_ack;
        pc_inc = mem_ack;
        nxt    = mem_ack ? S_DECODE : expired ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        dec_en = 1'b1;
        nxt    = S_EXEC;
      end
      S_EXEC: begin
        illegal = !is_onehot(dec_q);
        reg_we  = |op[D_MOVD:D_MOVA];
        reg_sel = {op[D_MOVC] | op[D_MOVD], op[D_MOVB] | op[D_MOVD]};
        acc_ld  = op[D_ADD] | op[D_SUB];
        alu_sub = op[D_SUB];
        pc_ld   = op[D_JMP] | (op[D_JG] & gt_flag);
        retire  = !(op[D_IN1] | op[D_OUT1] | op[D_MOVI]);
        nxt     = op[D_IN1] ? S_IO_IN : op[D_OUT1] ? S_IO_OUT : op[D_MOVI] ? S_IMM :
                  op[D_HALT] ? S_HALT : RET_ST;
      end
      S_IMM: begin
        mem_rd  = 1'b1;
        imm_ld  = mem_ack;
        pc_inc  = mem_ack;
        acc_ld  = mem_ack;
        acc_src = mem_ack ? ACC_IMM : ACC_ALU;
        retire  = mem_ack;
        nxt     = mem_ack ? RET_ST : expired ? S_FAULT : S_IMM;
      end
      S_IO_IN: begin
        in_ready = 1'b1;
        acc_ld   = in_valid;
        acc_src  = in_valid ? ACC_IN : ACC_ALU;
        retire   = in_valid;
        nxt      = in_valid ? RET_ST : S_IO_IN;
      end
      S_IO_OUT: begin
        out_valid = 1'b1;
        retire    = out_ready;
        nxt       = out_ready ? RET_ST : S_IO_OUT;
      end
      S_HALT: halted = 1'b1;
      S_FAULT: fault = 1'b1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
      S_STEP: nxt = step ? S_FETCH : S_STEP;
`endif
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: directed self-checking bench for cpu_ctrl_seq (default build)
module tb_cpu_ctrl_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ack = 1'b0, gt_flag = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] dec_vec = '0;
  logic mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, dec_en, reg_we, acc_ld, alu_sub;
  logic in_ready, out_valid, halted, fault, illegal;
  logic [1:0] reg_sel, acc_src;
  logic [15:0] insn_cnt;
  int checks = 0, errors = 0, n = 0;
  always #5 clk = ~clk;
  cpu_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ack(mem_ack), .dec_vec(dec_vec),
    .gt_flag(gt_flag), .in_valid(in_valid), .out_ready(out_ready),
    .mem_rd(mem_rd), .ir_ld(ir_ld), .imm_ld(imm_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .dec_en(dec_en), .reg_we(reg_we), .reg_sel(reg_sel), .acc_ld(acc_ld), .alu_sub(alu_sub),
    .acc_src(acc_src), .in_ready(in_ready), .out_valid(out_valid), .halted(halted),
    .fault(fault), .illegal(illegal), .insn_cnt(insn_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic fd(input logic [11:0] v);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("fetch_ir_ld", ir_ld, 1);
    chk("fetch_pc_inc", pc_inc, 1);
    @(negedge clk); mem_ack = 1'b0; dec_vec = v; #1;
    chk("decode_en", dec_en, 1);
    @(negedge clk); dec_vec = '0; #1;
  endtask
  initial begin
    #2;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_cnt", insn_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1; #1;
    chk("idle_mem_rd", mem_rd, 0);
    fd(12'h001);
    chk("mova_we", reg_we, 1);
    chk("mova_sel", reg_sel, 0);
    chk("mova_illegal", illegal, 0);
    chk("mova_dec_en", dec_en, 0);
    @(negedge clk); #1; n = 1;
    chk("mova_cnt", insn_cnt, n);
    chk("mova_back_fetch", mem_rd, 1);
    fd(12'h004);
    chk("movc_we", reg_we, 1);
    chk("movc_sel", reg_sel, 2);
    fd(12'h010); n++;
    chk("add_acc_ld", acc_ld, 1);
    chk("add_sub", alu_sub, 0);
    chk("add_src", acc_src, 0);
    chk("add_cnt", insn_cnt, n);
    fd(12'h020); n++;
    chk("sub_acc_ld", acc_ld, 1);
    chk("sub_sub", alu_sub, 1);
    gt_flag = 1'b0;
    fd(12'h080); n++;
    chk("jg0_pc_ld", pc_ld, 0);
    chk("jg0_cnt", insn_cnt, n);
    gt_flag = 1'b1;
    fd(12'h080); n++;
    chk("jg1_pc_ld", pc_ld, 1);
    chk("jg1_cnt", insn_cnt, n);
    gt_flag = 1'b0;
    fd(12'h040); n++;
    chk("jmp_pc_ld", pc_ld, 1);
    fd(12'h400); n++;
    chk("movi_exec_rd", mem_rd, 0);
    chk("movi_exec_cnt", insn_cnt, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("imm_wait_rd", mem_rd, 1);
      chk("imm_wait_ld", imm_ld, 0);
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("imm_ld", imm_ld, 1);
    chk("imm_pc_inc", pc_inc, 1);
    chk("imm_acc_ld", acc_ld, 1);
    chk("imm_src", acc_src, 2);
    fd(12'h100); n++;
    chk("in1_cnt", insn_cnt, n);
    @(negedge clk); #1;
    chk("in_ready", in_ready, 1);
    chk("in_wait_acc", acc_ld, 0);
    @(negedge clk); in_valid = 1'b1; #1;
    chk("in_acc_ld", acc_ld, 1);
    chk("in_src", acc_src, 1);
    fd(12'h200); n++;
    chk("out1_cnt", insn_cnt, n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("out_valid_hold", out_valid, 1);
      chk("out_hold_cnt", insn_cnt, n);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("out_valid_acc", out_valid, 1);
    fd(12'h003); n++;
    chk("ill_cnt_before", insn_cnt, n);
    chk("ill_pulse", illegal, 1);
    chk("ill_we", reg_we, 0);
    chk("ill_acc", acc_ld, 0);
    chk("ill_pc_ld", pc_ld, 0);
    fd(12'h800); n++;
    chk("ill_pulse_gone", illegal, 0);
    chk("ill_retired", insn_cnt, n);
    start = 1'b1; n++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      chk("halted", halted, 1);
      chk("halt_mem_rd", mem_rd, 0);
      chk("halt_cnt", insn_cnt, n);
    end
    rst_n = 1'b0; #1;
    chk("halt_rst", halted, 0);
    chk("halt_rst_cnt", insn_cnt, 0);
    @(negedge clk); rst_n = 1'b1; start = 1'b1; mem_ack = 1'b0; #1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); start = 1'b0; #1;
      chk("late_ack_wait", mem_rd, 1);
    end
    fd(12'h002);
    chk("late_ack_fault", fault, 0);
    chk("late_ack_movb", reg_sel, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1; start = 1'b1; mem_ack = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); start = 1'b0; #1;
      chk("timeout_wait", mem_rd, 1);
      chk("timeout_no_fault", fault, 0);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = 1'b1; #1;
      chk("fault_sticky", fault, 1);
      chk("fault_mem_rd", mem_rd, 0);
    end
    rst_n = 1'b0; #1;
    chk("fault_rst", fault, 0);
    @(negedge clk); rst_n = 1'b1; start = 1'b1; mem_ack = 1'b0; #1;
    @(negedge clk); start = 1'b0; #1;
    chk("mid_rd", mem_rd, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_rd", mem_rd, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
